// File: rtl/disc_pkg.sv
// Shared types and widths for the discriminator scheduler.
// The FLUSH state exists only when DISC_WATCHDOG_EN is defined.
package disc_pkg;

   localparam int IN_W  = 32;
   localparam int OUT_W = 27;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE
`ifdef DISC_WATCHDOG_EN
      ,
      ST_FLUSH
`endif
   } disc_state_t;

   typedef struct packed {
      logic [OUT_W-1:0] prob;
      logic             state;
   } disc_res_t;

endpackage

// File: rtl/disc_tag_fifo.sv
// Synchronous tag FIFO holding the channel index of each in-flight inference.
module disc_tag_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          push_ok, pop_ok;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop & ~empty;
   // A push while full is accepted only when a pop frees the head in the same cycle.
   assign push_ok = push & (~full | pop_ok);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/disc_scheduler.sv
// Round-robin scheduler sharing one discriminator across NUM_CH channels, with tagged results.
// Defining DISC_WATCHDOG_EN adds the in-flight watchdog, sticky timeout and FLUSH state.
module disc_scheduler
   import disc_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int TAG_DEPTH = 8,
   parameter int TIMEOUT   = 1024
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         ch_valid,
   input  logic [NUM_CH*2*IN_W-1:0]  ch_data,
   output logic [NUM_CH-1:0]         ch_pending,
   output logic                      disc_start,
   output logic [2*IN_W-1:0]         disc_data,
   input  logic                      disc_ready,
   input  logic                      disc_done,
   input  logic                      disc_state,
   input  logic [OUT_W-1:0]          disc_prob,
   output logic                      res_valid,
   output logic [$clog2(NUM_CH)-1:0] res_ch,
   output logic [OUT_W-1:0]          res_prob,
   output logic                      res_state,
   output logic [NUM_CH-1:0]         overflow,
   output logic                      timeout
);

   localparam int CH_W = $clog2(NUM_CH);
   localparam int DW   = 2*IN_W;

   logic [NUM_CH-1:0] pending, pending_nxt, ovf_set;
   logic [DW-1:0]     hold [NUM_CH];
   logic [CH_W-1:0]   rr_ptr, gnt_idx, cand, tag_head;
   logic              gnt_found, granted, issue, pop, flush, busy, wd_fire;
   logic              fifo_full, fifo_empty;
   disc_state_t       state, state_nxt;
   disc_res_t         res_q;

   assign ch_pending = pending;
   assign res_prob   = res_q.prob;
   assign res_state  = res_q.state;
   assign busy       = (|pending) | ~fifo_empty;
   assign pop        = disc_done & ~fifo_empty & ~flush;
   assign issue      = disc_ready & gnt_found & (~fifo_full | pop) & ~flush;

   // Search starts at rr_ptr, the channel after the last grant.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         cand = CH_W'((32'(rr_ptr) + k) % 32'(NUM_CH));
         if (!gnt_found && pending[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_comb begin
      pending_nxt = pending;
      ovf_set     = '0;
      granted     = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         granted        = issue && (gnt_idx == CH_W'(i));
         ovf_set[i]     = ch_valid[i] & pending[i] & ~granted;
         pending_nxt[i] = ch_valid[i] | (pending[i] & ~granted);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending    <= '0;
         overflow   <= '0;
         rr_ptr     <= '0;
         disc_start <= 1'b0;
         disc_data  <= '0;
         res_valid  <= 1'b0;
         res_ch     <= '0;
         res_q      <= '0;
         for (int unsigned i = 0; i < NUM_CH; i++) hold[i] <= '0;
      end else begin
         pending    <= pending_nxt;
         overflow   <= overflow | ovf_set;
         disc_start <= issue;
         res_valid  <= pop;
         // Hold is read before this cycle's writes, so a same-cycle request is queued, not issued.
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (ch_valid[i]) hold[i] <= ch_data[i*DW +: DW];
         if (issue) begin
            disc_data <= hold[gnt_idx];
            rr_ptr    <= (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + 1'b1;
         end
         if (pop) begin
            res_ch      <= tag_head;
            res_q.prob  <= disc_prob;
            res_q.state <= disc_state;
         end
      end
   end

   disc_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .W     (CH_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (issue),
      .pop   (pop),
      .flush (flush),
      .din   (gnt_idx),
      .dout  (tag_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef DISC_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT+1);
   logic [WD_W-1:0] wd_cnt;

   assign wd_fire = (state == ST_ACTIVE) && !fifo_empty && !disc_done &&
                    (wd_cnt == WD_W'(TIMEOUT-1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= timeout | wd_fire;
         if (disc_done || fifo_empty || state != ST_ACTIVE || wd_fire) wd_cnt <= '0;
         else wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      flush     = 1'b0;
      case (state)
         ST_IDLE:   if (busy) state_nxt = ST_ACTIVE;
         ST_ACTIVE: begin
`ifdef DISC_WATCHDOG_EN
            if (wd_fire)    state_nxt = ST_FLUSH;
            else
`endif
            if (!busy)      state_nxt = ST_IDLE;
         end
`ifdef DISC_WATCHDOG_EN
         ST_FLUSH: begin
            flush     = 1'b1;
            state_nxt = (|pending) ? ST_ACTIVE : ST_IDLE;
         end
`endif
         default:   state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_disc_scheduler.sv
// Self-checking bench for disc_scheduler: vector table plus issue/result scoreboard.
module tb_disc_scheduler;

   localparam int NUM_CH    = 4;
   localparam int TAG_DEPTH = 8;
`ifdef DISC_WATCHDOG_EN
   localparam int TIMEOUT   = 16;
`else
   localparam int TIMEOUT   = 1024;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [3:0]        ch_valid;
   logic [255:0]      ch_data;
   logic [3:0]        ch_pending;
   logic              disc_start;
   logic [63:0]       disc_data;
   logic              disc_ready, disc_done, disc_state;
   logic [26:0]       disc_prob;
   logic              res_valid;
   logic [1:0]        res_ch;
   logic [26:0]       res_prob;
   logic              res_state;
   logic [3:0]        overflow;
   logic              timeout;

   disc_scheduler #(
      .NUM_CH    (NUM_CH),
      .TAG_DEPTH (TAG_DEPTH),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ch_valid   (ch_valid),
      .ch_data    (ch_data),
      .ch_pending (ch_pending),
      .disc_start (disc_start),
      .disc_data  (disc_data),
      .disc_ready (disc_ready),
      .disc_done  (disc_done),
      .disc_state (disc_state),
      .disc_prob  (disc_prob),
      .res_valid  (res_valid),
      .res_ch     (res_ch),
      .res_prob   (res_prob),
      .res_state  (res_state),
      .overflow   (overflow),
      .timeout    (timeout)
   );

   always #5 clk = ~clk;

   typedef struct { logic [1:0] ch; logic [63:0] data; } iss_t;
   typedef struct { logic [1:0] ch; logic [26:0] prob; logic st; } res_t;
   typedef struct { int ch; logic [63:0] data; int dly; logic [26:0] prob; logic st; } vec_t;

   iss_t       exp_iss[$];
   logic [1:0] inflight[$];
   res_t       exp_res[$];
   iss_t       mi;
   res_t       mr;
   int         n_cmp = 0;
   int         n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] mkdata(input int ch, input int batch);
      return {32'(ch + 1), 32'hA000_0000 | 32'(batch)};
   endfunction

   task automatic drive_valid(input logic [3:0] mask, input int batch);
      ch_valid = mask;
      for (int i = 0; i < 4; i++) begin
         if (mask[i]) begin
            ch_data[i*64 +: 64] = mkdata(i, batch);
            exp_iss.push_back('{ch: 2'(i), data: mkdata(i, batch)});
         end
      end
   endtask

   task automatic drive_done(input logic [26:0] p, input logic s);
      res_t r;
      disc_done  = 1'b1;
      disc_prob  = p;
      disc_state = s;
      if (inflight.size() > 0) begin
         r.ch   = inflight.pop_front();
         r.prob = p;
         r.st   = s;
         exp_res.push_back(r);
      end
   endtask

   task automatic do_reset();
      rst        = 1'b0;
      ch_valid   = '0;
      disc_done  = 1'b0;
      disc_ready = 1'b1;
      tick();
      tick();
      exp_iss.delete();
      inflight.delete();
      exp_res.delete();
      rst = 1'b1;
      tick();
   endtask

   // Issues are matched against requested data; results against tags the model recorded at issue.
   always @(negedge clk) begin
      if (rst) begin
         if (disc_start) begin
            if (exp_iss.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_issue: got disc_start=1 data=%h want no issue", disc_data);
            end else begin
               mi = exp_iss.pop_front();
               chk("issue_data", disc_data, mi.data);
               inflight.push_back(mi.ch);
            end
         end
         if (res_valid) begin
            if (exp_res.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_result: got res_valid=1 ch=%0d want no result", res_ch);
            end else begin
               mr = exp_res.pop_front();
               chk("res_ch", 64'(res_ch), 64'(mr.ch));
               chk("res_prob", 64'(res_prob), 64'(mr.prob));
               chk("res_state", 64'(res_state), 64'(mr.st));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1, "time budget exceeded");
   end

   initial begin
      vec_t vt[4];
      int   w;
      vt[0] = '{ch: 2, data: 64'h0000_0010_FFFF_FFF0, dly: 5, prob: 27'h123_4567, st: 1'b1};
      vt[1] = '{ch: 0, data: 64'h8000_0001_7FFF_FFFF, dly: 3, prob: 27'h7FF_FFFF, st: 1'b0};
      vt[2] = '{ch: 3, data: 64'hDEAD_BEEF_0BAD_F00D, dly: 1, prob: 27'h000_0001, st: 1'b1};
      vt[3] = '{ch: 1, data: 64'h0000_0000_0000_0001, dly: 7, prob: 27'h2AA_AAAA, st: 1'b0};

      rst = 1'b0; ch_valid = '0; ch_data = '0; disc_ready = 1'b0;
      disc_done = 1'b0; disc_state = 1'b0; disc_prob = '0;
      #1;
      chk("rst_disc_start", 64'(disc_start), 0);
      chk("rst_disc_data", disc_data, 0);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_pending", 64'(ch_pending), 0);
      chk("rst_overflow", 64'(overflow), 0);
      chk("rst_timeout", 64'(timeout), 0);
      do_reset();

      // Single uncontended requests: c+2 latency and one-cycle tagged result.
      foreach (vt[v]) begin
         ch_valid = 4'(1 << vt[v].ch);
         ch_data[vt[v].ch*64 +: 64] = vt[v].data;
         exp_iss.push_back('{ch: 2'(vt[v].ch), data: vt[v].data});
         tick();
         ch_valid = '0;
         @(negedge clk);
         chk("lat_c1_start", 64'(disc_start), 0);
         chk("lat_c1_pending", 64'(ch_pending), 64'(1 << vt[v].ch));
         tick();
         @(negedge clk);
         chk("lat_c2_start", 64'(disc_start), 1);
         chk("lat_c2_pending", 64'(ch_pending), 0);
         repeat (vt[v].dly) tick();
         drive_done(vt[v].prob, vt[v].st);
         tick();
         disc_done = 1'b0;
         @(negedge clk);
         chk("vec_res_valid", 64'(res_valid), 1);
         chk("vec_res_ch", 64'(res_ch), 64'(vt[v].ch));
         tick();
         @(negedge clk);
         chk("vec_res_pulse", 64'(res_valid), 0);
         chk("vec_res_hold", 64'(res_prob), 64'(vt[v].prob));
      end

      // All four channels at once: consecutive grants in channel order.
      do_reset();
      drive_valid(4'hF, 1);
      tick();
      ch_valid = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         @(negedge clk);
         chk("rr_start", 64'(disc_start), 1);
      end
      tick();
      @(negedge clk);
      chk("rr_idle_after", 64'(disc_start), 0);
      for (int k = 0; k < 4; k++) begin
         drive_done(27'(k * 27'h11_1111 + 5), k[0]);
         tick();
      end
      disc_done = 1'b0;
      repeat (3) tick();

      // Back-pressure: second strobe overflows and replaces held data.
      do_reset();
      disc_ready = 1'b0;
      ch_valid = 4'b0010; ch_data[64 +: 64] = 64'h1111_1111_2222_2222;
      tick();
      ch_valid = '0;
      tick();
      ch_valid = 4'b0010; ch_data[64 +: 64] = 64'h3333_3333_4444_4444;
      exp_iss.push_back('{ch: 2'd1, data: 64'h3333_3333_4444_4444});
      tick();
      ch_valid = '0;
      @(negedge clk);
      chk("ovf_set", 64'(overflow), 64'h2);
      chk("ovf_pending", 64'(ch_pending), 64'h2);
      chk("ovf_no_issue", 64'(disc_start), 0);
      disc_ready = 1'b1;
      repeat (4) tick();
      @(negedge clk);
      chk("ovf_sticky", 64'(overflow), 64'h2);
      drive_done(27'h55, 1'b1);
      tick();
      disc_done = 1'b0;
      repeat (2) tick();

`ifndef DISC_WATCHDOG_EN
      // Fill the tag FIFO, stall the 9th, then simultaneous done and issue.
      do_reset();
      drive_valid(4'hF, 2);
      tick();
      ch_valid = '0;
      repeat (4) tick();
      drive_valid(4'hF, 3);
      tick();
      ch_valid = '0;
      repeat (6) tick();
      ch_valid = 4'b0001; ch_data[63:0] = 64'h9999_0000_0000_0009;
      exp_iss.push_back('{ch: 2'd0, data: 64'h9999_0000_0000_0009});
      tick();
      ch_valid = '0;
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         chk("full_no_issue", 64'(disc_start), 0);
      end
      chk("full_pending", 64'(ch_pending), 64'h1);
      chk("full_no_ovf", 64'(overflow), 0);
      chk("full_count", 64'(dut.u_fifo.count), 8);
      tick();
      drive_done(27'h100, 1'b0);
      tick();
      disc_done = 1'b0;
      @(negedge clk);
      chk("full_swap_issue", 64'(disc_start), 1);
      chk("full_swap_count", 64'(dut.u_fifo.count), 8);
      for (int k = 0; k < 8; k++) begin
         tick();
         drive_done(27'(27'h200 + k), k[1]);
      end
      tick();
      disc_done = 1'b0;
      tick();
      drive_done(27'h3FF, 1'b1);
      tick();
      disc_done = 1'b0;
      @(negedge clk);
      chk("empty_done_ignored", 64'(res_valid), 0);
`endif

      // Reset with three tags in flight.
      do_reset();
      drive_valid(4'b1111, 4);
      tick();
      ch_valid = '0;
      repeat (6) tick();
      drive_done(27'h6_5432, 1'b1);
      tick();
      disc_done = 1'b0;
      ch_valid = 4'b0100; ch_data[128 +: 64] = 64'h7;
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_res_prob", 64'(res_prob), 0);
      chk("midrst_res_valid", 64'(res_valid), 0);
      chk("midrst_res_ch", 64'(res_ch), 0);
      chk("midrst_disc_data", disc_data, 0);
      chk("midrst_pending", 64'(ch_pending), 0);
      chk("midrst_count", 64'(dut.u_fifo.count), 0);
      exp_iss.delete(); inflight.delete(); exp_res.delete();
      ch_valid = '0;
      tick();
      rst = 1'b1;
      tick();
      drive_done(27'h1, 1'b1);
      tick();
      disc_done = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("postrst_no_res", 64'(res_valid), 0);
         tick();
      end

`ifdef DISC_WATCHDOG_EN
      do_reset();
      drive_valid(4'b0001, 5);
      tick();
      ch_valid = '0;
      w = 0;
      while (!timeout && w < 40) begin
         tick();
         w++;
      end
      chk("wd_timeout", 64'(timeout), 1);
      chk("wd_window", 64'(w >= 16 && w <= 20), 1);
      tick();
      tick();
      chk("wd_fifo_empty", 64'(dut.u_fifo.empty), 1);
      inflight.delete();
      drive_done(27'h2, 1'b0);
      tick();
      disc_done = 1'b0;
      @(negedge clk);
      chk("wd_no_res", 64'(res_valid), 0);
`else
      chk("timeout_tied", 64'(timeout), 0);
`endif

      chk("iss_drained", 64'(exp_iss.size()), 0);
      chk("res_drained", 64'(exp_res.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
